puf_session_controller: RTL
===========================

# puf_session_controller

Parametrised top-level sequencer for the PUF-over-UART path, replacing the single-PUF main state machine. It decodes one UART command byte, then either streams the device ID or loads an N-byte challenge into one of `N_PUF` PUF instances and drains the response FIFO to the UART. Versus the single-PUF controller it adds per-channel select, configurable byte counts, a PUF timeout, and status-byte error reporting. Sits between the UART RX/TX, the challenge register file, the PUF array and the response FIFO.

## Interface
- `N_PUF`, 4, number of PUF channels (1..16)
- `CHALLENGE_BYTES`, 8, challenge bytes per request (≥1)
- `ID_BYTES`, 4, ID bytes sent per ID request (≥1)
- `PUF_TIMEOUT`, 1024, max cycles in RUN_PUF before abort (≥2)
- `IDX_W`, derived: `$clog2` of max(CHALLENGE_BYTES, ID_BYTES), min 1

- `clk`  in  1  system clock
- `reset_n`  in  1  synchronous, active-low reset
- `rx_valid`  in  1  one-cycle strobe, `rx_data` valid
- `rx_data`  in  8  received byte
- `rx_enable`  out  1  UART receiver enable
- `tx_busy`  in  1  UART transmitter busy
- `tx_enable`  out  1  one-cycle transmit start pulse
- `tx_data_sel`  out  2  TX source: 0 ID ROM, 1 FIFO, 2 `status_byte`
- `status_byte`  out  8  error code for TX source 2
- `byte_idx`  out  IDX_W  current challenge/ID byte index
- `store_challenge`  out  1  write strobe into challenge register file
- `puf_sel`  out  clog2(N_PUF), min 1  selected channel
- `puf_enable`  out  N_PUF  one-hot run enable
- `puf_done`  in  N_PUF  per-channel done pulse
- `puf_reset`, `uart_reset`, `fifo_reset`  out  1 each  subsystem resets, active-high
- `fifo_empty`  in  1  response FIFO empty
- `fifo_re`  out  1  one-cycle FIFO read pulse
- `busy`  out  1  high in every state except IDLE

## Operation
- Command byte: `[7:4]` opcode, `[3:0]` channel. 0x1 = ID request; 0x2 = challenge/response on channel; 0x3 = soft reset (→ INIT). Any other opcode, or opcode 0x2 with channel ≥ N_PUF → ERR, status 0xE0.
- States: INIT, IDLE, SEND_ID, LOAD_CH, RUN_PUF, DRAIN_RD, DRAIN_TX, ERR, TX_WAIT_HI, TX_WAIT_LO.
- INIT: `puf_reset`/`uart_reset`/`fifo_reset` = 1 for exactly one cycle, then IDLE.
- IDLE: `rx_enable` = 1; on `rx_valid` decode `rx_data`, latch `puf_sel`, clear `byte_idx`.
- SEND_ID: per byte, `tx_data_sel` = 0, pulse `tx_enable`, then TX wait; increment `byte_idx`. After ID_BYTES bytes → IDLE.
- LOAD_CH: `rx_enable` = 1; each `rx_valid` gives a `store_challenge` pulse in the same cycle with the current `byte_idx`, then increments it. After byte CHALLENGE_BYTES-1 → RUN_PUF.
- RUN_PUF: `puf_enable[puf_sel]` = 1, all other bits 0. Exits to DRAIN_RD on `puf_done[puf_sel]`.
- DRAIN_RD: if `fifo_empty` → IDLE. Otherwise pulse `fifo_re` → DRAIN_TX.
- DRAIN_TX: `tx_data_sel` = 1, pulse `tx_enable`, TX wait, then → DRAIN_RD.
- ERR: `tx_data_sel` = 2, pulse `tx_enable`, TX wait, pulse `puf_reset` for one cycle, → IDLE.
- TX wait: stay in TX_WAIT_HI until `tx_busy` = 1, then in TX_WAIT_LO until `tx_busy` = 0, then return to the calling state.

## Timing
- `reset_n` low: state INIT. Resets = 1. All other outputs = 0. `status_byte` = 0x00, `byte_idx` = 0, `puf_sel` = 0.
- First edge with `reset_n` high: INIT for one cycle, then IDLE. Reset mid-operation abandons the transaction; there is no partial TX.
- Command byte → first `tx_enable` (ID) or `rx_enable` (challenge): 1 cycle.
- Last challenge `store_challenge` → `puf_enable` high: next cycle.
- `puf_done` → first `fifo_re`: 1 cycle. `fifo_re` → `tx_enable`: 1 cycle.
- `tx_enable` is never asserted while `tx_busy` = 1. It is a pulse exactly one cycle wide.
- Ignored inputs:
  - `rx_valid` outside IDLE/LOAD_CH.
  - `puf_done` outside RUN_PUF, or on a non-selected channel.
  - `fifo_empty` outside DRAIN_RD.
- `rx_valid` and `puf_done` in the same cycle: only the one relevant to the current state acts.
- `byte_idx` wraps to 0 on state exit, never mid-sequence.

## Configuration
- `PUF_CTRL_TIMEOUT_EN` defined:
  - A cycle counter runs in RUN_PUF.
  - At PUF_TIMEOUT cycles without `puf_done[puf_sel]` → ERR with status 0xE1 and `puf_enable` dropped.
  - `puf_done` on the terminal-count cycle wins over the timeout.
- Undefined: RUN_PUF waits indefinitely, 0xE1 is never produced, and no counter is synthesised.

## Test plan
- Reset release, then cmd 0x10 → `uart_reset` high one cycle after release. 4 `tx_enable` pulses, `tx_data_sel` = 0, `byte_idx` 0..3, each pulse only after `tx_busy` falls. Then IDLE with `busy` = 0.
- Cmd 0x22, 8 challenge bytes, `puf_done[2]` after 5 cycles, FIFO holds 3 entries → 8 `store_challenge` pulses (idx 0..7). `puf_enable` = 4'b0100. 3 `fifo_re` / 3 `tx_enable` pulses with `tx_data_sel` = 1. Then IDLE.
- Cmd 0x27 with N_PUF = 4 → no `puf_enable`. One TX with `status_byte` = 0xE0, `puf_reset` pulse, IDLE. Same for cmd 0x50.
- With `PUF_CTRL_TIMEOUT_EN`, cmd 0x21 and no `puf_done` → `puf_enable[1]` held exactly 1024 cycles, then TX of 0xE1. `puf_done[0]` during the wait has no effect.
- `reset_n` pulled low mid-DRAIN_TX → next edge: all outputs at reset values, `tx_enable` = 0. Sequence restarts through INIT.
- Cmd 0x30 → INIT for one cycle with the three reset outputs = 1. `rx_valid` during SEND_ID produces no `store_challenge`.

Source files
------------

// File: rtl/puf_session_controller_if.sv
// rtl/puf_session_controller_if.sv - signal bundle between the PUF session controller and the UART/PUF/FIFO subsystems
// Purpose: groups every handshake and bus signal of puf_session_controller so
//          the controller and its environment connect through one port.
// Parameters: N_PUF (channels), CHALLENGE_BYTES, ID_BYTES (set IDX_W/SEL_W widths).
// Signals:
//   rx_valid/rx_data/rx_enable          UART receive side
//   tx_busy/tx_enable/tx_data_sel       UART transmit side
//   status_byte                         error code for TX source 2
//   byte_idx/store_challenge            challenge register file / ID ROM index
//   puf_sel/puf_enable/puf_done         PUF array
//   puf_reset/uart_reset/fifo_reset     active-high subsystem resets
//   fifo_empty/fifo_re                  response FIFO
//   busy                                controller not idle
// Modports: master = controller side, slave = environment side.
interface puf_session_controller_if #(
  parameter int N_PUF           = 4,
  parameter int CHALLENGE_BYTES = 8,
  parameter int ID_BYTES        = 4
);
  localparam int MAX_BYTES = (CHALLENGE_BYTES > ID_BYTES) ? CHALLENGE_BYTES : ID_BYTES;
  localparam int IDX_W     = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam int SEL_W     = (N_PUF > 1) ? $clog2(N_PUF) : 1;

  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             rx_enable;
  logic             tx_busy;
  logic             tx_enable;
  logic [1:0]       tx_data_sel;
  logic [7:0]       status_byte;
  logic [IDX_W-1:0] byte_idx;
  logic             store_challenge;
  logic [SEL_W-1:0] puf_sel;
  logic [N_PUF-1:0] puf_enable;
  logic [N_PUF-1:0] puf_done;
  logic             puf_reset;
  logic             uart_reset;
  logic             fifo_reset;
  logic             fifo_empty;
  logic             fifo_re;
  logic             busy;

  modport master (
    input  rx_valid, rx_data, tx_busy, puf_done, fifo_empty,
    output rx_enable, tx_enable, tx_data_sel, status_byte, byte_idx,
           store_challenge, puf_sel, puf_enable, puf_reset, uart_reset,
           fifo_reset, fifo_re, busy
  );

  modport slave (
    output rx_valid, rx_data, tx_busy, puf_done, fifo_empty,
    input  rx_enable, tx_enable, tx_data_sel, status_byte, byte_idx,
           store_challenge, puf_sel, puf_enable, puf_reset, uart_reset,
           fifo_reset, fifo_re, busy
  );
endinterface

// File: rtl/puf_session_controller.sv
// rtl/puf_session_controller.sv - UART command sequencer for a multi-channel PUF array
// Purpose: decodes one UART command byte, then streams the device ID, loads a
//          challenge into the selected PUF and drains its response FIFO to the
//          UART, or reports an error code through the status byte.
// Ports:
//   clk      system clock
//   reset_n  synchronous active-low reset
//   bus      puf_session_controller_if.master (UART RX/TX, challenge file,
//            PUF array, response FIFO, subsystem resets, busy)
// Optional feature: define PUF_CTRL_TIMEOUT_EN to abort RUN_PUF after
//   PUF_TIMEOUT cycles with status 0xE1.
module puf_session_controller #(
  parameter int N_PUF           = 4,
  parameter int CHALLENGE_BYTES = 8,
  parameter int ID_BYTES        = 4,
  parameter int PUF_TIMEOUT     = 1024
) (
  input  logic                            clk,
  input  logic                            reset_n,
  puf_session_controller_if.master        bus
);
  localparam int MAX_BYTES = (CHALLENGE_BYTES > ID_BYTES) ? CHALLENGE_BYTES : ID_BYTES;
  localparam int IDX_W     = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam int SEL_W     = (N_PUF > 1) ? $clog2(N_PUF) : 1;

  localparam logic [IDX_W-1:0] ID_LAST = IDX_W'(ID_BYTES - 1);
  localparam logic [IDX_W-1:0] CH_LAST = IDX_W'(CHALLENGE_BYTES - 1);

  localparam logic [3:0] OP_ID    = 4'h1;
  localparam logic [3:0] OP_CHAL  = 4'h2;
  localparam logic [3:0] OP_RESET = 4'h3;

  localparam logic [7:0] ST_BAD_CMD = 8'hE0;

  typedef enum logic [3:0] {
    INIT,
    IDLE,
    SEND_ID,
    LOAD_CH,
    RUN_PUF,
    DRAIN_RD,
    DRAIN_TX,
    ERR,
    TX_WAIT_HI,
    TX_WAIT_LO
  } state_t;

  state_t           state, state_n;
  state_t           ret, ret_n;          // state that started the current TX wait
  logic [IDX_W-1:0] byte_idx, byte_idx_n;
  logic [SEL_W-1:0] puf_sel, puf_sel_n;
  logic [7:0]       status, status_n;
  logic             err_sent, err_sent_n; // ERR has transmitted its status byte
  logic             chan_ok;
  logic             sel_done;
  logic [1:0]       ret_sel;

`ifdef PUF_CTRL_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(PUF_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PUF_TIMEOUT - 1);
  localparam logic [7:0]       ST_TIMEOUT = 8'hE1;

  logic [CNT_W-1:0] cnt, cnt_n;
`endif

  assign chan_ok  = ({28'd0, bus.rx_data[3:0]} < 32'(N_PUF));
  assign sel_done = bus.puf_done[puf_sel];

  // Keep the TX source stable for the whole UART transfer.
  always_comb begin
    ret_sel = 2'd2;
    case (ret)
      SEND_ID:  ret_sel = 2'd0;
      DRAIN_TX: ret_sel = 2'd1;
      default:  ret_sel = 2'd2;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= INIT;
      ret      <= INIT;
      byte_idx <= '0;
      puf_sel  <= '0;
      status   <= 8'h00;
      err_sent <= 1'b0;
`ifdef PUF_CTRL_TIMEOUT_EN
      cnt      <= '0;
`endif
    end else begin
      state    <= state_n;
      ret      <= ret_n;
      byte_idx <= byte_idx_n;
      puf_sel  <= puf_sel_n;
      status   <= status_n;
      err_sent <= err_sent_n;
`ifdef PUF_CTRL_TIMEOUT_EN
      cnt      <= cnt_n;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    ret_n      = ret;
    byte_idx_n = byte_idx;
    puf_sel_n  = puf_sel;
    status_n   = status;
    err_sent_n = err_sent;
`ifdef PUF_CTRL_TIMEOUT_EN
    cnt_n      = '0;
`endif

    bus.rx_enable       = 1'b0;
    bus.tx_enable       = 1'b0;
    bus.tx_data_sel     = 2'd0;
    bus.store_challenge = 1'b0;
    bus.puf_enable      = '0;
    bus.puf_reset       = 1'b0;
    bus.uart_reset      = 1'b0;
    bus.fifo_reset      = 1'b0;
    bus.fifo_re         = 1'b0;

    case (state)
      INIT: begin
        bus.puf_reset  = 1'b1;
        bus.uart_reset = 1'b1;
        bus.fifo_reset = 1'b1;
        byte_idx_n     = '0;
        puf_sel_n      = '0;
        status_n       = 8'h00;
        err_sent_n     = 1'b0;
        state_n        = IDLE;
      end

      IDLE: begin
        bus.rx_enable = 1'b1;
        if (bus.rx_valid) begin
          byte_idx_n = '0;
          case (bus.rx_data[7:4])
            OP_ID:    state_n = SEND_ID;
            OP_CHAL: begin
              if (chan_ok) begin
                puf_sel_n = bus.rx_data[SEL_W-1:0];
                state_n   = LOAD_CH;
              end else begin
                status_n = ST_BAD_CMD;
                state_n  = ERR;
              end
            end
            OP_RESET: state_n = INIT;
            default: begin
              status_n = ST_BAD_CMD;
              state_n  = ERR;
            end
          endcase
        end
      end

      SEND_ID: begin
        bus.tx_data_sel = 2'd0;
        if (!bus.tx_busy) begin
          bus.tx_enable = 1'b1;
          ret_n         = SEND_ID;
          state_n       = TX_WAIT_HI;
        end
      end

      LOAD_CH: begin
        bus.rx_enable = 1'b1;
        if (bus.rx_valid) begin
          bus.store_challenge = 1'b1;
          if (byte_idx == CH_LAST) begin
            byte_idx_n = '0;
            state_n    = RUN_PUF;
          end else begin
            byte_idx_n = byte_idx + IDX_W'(1);
          end
        end
      end

      RUN_PUF: begin
        bus.puf_enable = N_PUF'(1) << puf_sel;
        // A done pulse on the terminal-count cycle still counts as success.
        if (sel_done) begin
          state_n = DRAIN_RD;
        end
`ifdef PUF_CTRL_TIMEOUT_EN
        else if (cnt == CNT_LAST) begin
          status_n = ST_TIMEOUT;
          state_n  = ERR;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
`endif
      end

      DRAIN_RD: begin
        if (bus.fifo_empty) begin
          state_n = IDLE;
        end else begin
          bus.fifo_re = 1'b1;
          state_n     = DRAIN_TX;
        end
      end

      DRAIN_TX: begin
        bus.tx_data_sel = 2'd1;
        if (!bus.tx_busy) begin
          bus.tx_enable = 1'b1;
          ret_n         = DRAIN_TX;
          state_n       = TX_WAIT_HI;
        end
      end

      ERR: begin
        bus.tx_data_sel = 2'd2;
        if (err_sent) begin
          bus.puf_reset = 1'b1;
          err_sent_n    = 1'b0;
          state_n       = IDLE;
        end else if (!bus.tx_busy) begin
          bus.tx_enable = 1'b1;
          ret_n         = ERR;
          state_n       = TX_WAIT_HI;
        end
      end

      TX_WAIT_HI: begin
        bus.tx_data_sel = ret_sel;
        if (bus.tx_busy) begin
          state_n = TX_WAIT_LO;
        end
      end

      TX_WAIT_LO: begin
        bus.tx_data_sel = ret_sel;
        if (!bus.tx_busy) begin
          case (ret)
            SEND_ID: begin
              // Advance only after the byte has left, so the ID ROM index is
              // stable for the whole transfer.
              if (byte_idx == ID_LAST) begin
                byte_idx_n = '0;
                state_n    = IDLE;
              end else begin
                byte_idx_n = byte_idx + IDX_W'(1);
                state_n    = SEND_ID;
              end
            end
            DRAIN_TX: state_n = DRAIN_RD;
            default: begin
              err_sent_n = 1'b1;
              state_n    = ERR;
            end
          endcase
        end
      end

      default: state_n = INIT;
    endcase
  end

  assign bus.status_byte = status;
  assign bus.byte_idx    = byte_idx;
  assign bus.puf_sel     = puf_sel;
  // INIT is the reset image, so busy reads 0 while reset_n is held low.
  assign bus.busy        = reset_n && (state != IDLE);
endmodule
